// File: rtl/sd_pkg.sv
// sd_pkg: SD SPI command indices, R1 bit positions, framing constants and frame FSM states
package sd_pkg;
  localparam logic [5:0] CMD0 = 6'd0;
  localparam logic [5:0] CMD8 = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam int R1_IDLE = 0;
  localparam int R1_ILLEGAL_CMD = 2;
  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam int BLOCK_BYTES = 512;
  typedef enum logic [2:0] {HUNT, RX_CMD, NCR, TX_RESP, NAC, TX_DATA, TX_CRC, TX_END} state_e;
  function automatic logic [7:0] r1_byte(input logic idle, input logic illegal);
    r1_byte = 8'h00;
    r1_byte[R1_IDLE] = idle;
    r1_byte[R1_ILLEGAL_CMD] = illegal;
  endfunction
endpackage

// File: rtl/sd_spi_slave_shifter.sv
// sd_spi_slave_shifter: synchronizes SPI pins, strobes received bits and shifts tx bytes out on falling spi_clk
module sd_spi_slave_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk_i,
  input  logic       cs_i,
  input  logic       mosi_i,
  input  logic       tx_en_i,
  input  logic [7:0] tx_byte_i,
  output logic       desel_o,
  output logic       rx_stb_o,
  output logic       rx_bit_o,
  output logic       tx_ack_o,
  output logic       miso_o
);
  logic [2:0] sclk_q;
  logic [1:0] cs_q, mosi_q;
  logic [6:0] tx_sr_q;
  logic [2:0] tx_cnt_q;
  logic miso_q, fall;
  assign desel_o = cs_q[1];
  assign rx_stb_o = sclk_q[1] && !sclk_q[2] && !desel_o;
  assign rx_bit_o = mosi_q[1];
  assign fall = !sclk_q[1] && sclk_q[2];
  assign tx_ack_o = fall && tx_en_i && !desel_o && tx_cnt_q == 3'd0;
  assign miso_o = miso_q;
  // A new byte is loaded on the falling edge that closes the previous byte, so its MSB is valid for the next rise
  always_ff @(posedge clk)
    if (rst) begin
      sclk_q <= 3'b000;
      cs_q <= 2'b11;
      mosi_q <= 2'b11;
      tx_sr_q <= 7'h7F;
      tx_cnt_q <= 3'd0;
      miso_q <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk_i};
      cs_q <= {cs_q[0], cs_i};
      mosi_q <= {mosi_q[0], mosi_i};
      if (!tx_en_i || desel_o) begin
        tx_cnt_q <= 3'd0;
        miso_q <= 1'b1;
      end else if (fall) begin
        tx_cnt_q <= tx_cnt_q + 3'd1;
        {miso_q, tx_sr_q} <= tx_cnt_q == 3'd0 ? tx_byte_i : {tx_sr_q, 1'b1};
      end
    end
endmodule

// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder: SPI-mode SD card model answering the init sequence and serving CMD17 block reads
module sd_spi_card_responder
  import sd_pkg::*;
#(
  parameter int unsigned ACMD41_BUSY_CNT = 2,
  parameter int unsigned NCR_BYTES = 1,
  parameter int unsigned NAC_BYTES = 2,
  parameter logic [31:0] OCR_VALUE = 32'hC0FF8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk_i,
  input  logic        cs_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic [31:0] blk_addr_o,
  output logic        data_req_o,
  input  logic [7:0]  data_in_i,
  output logic        in_idle_o,
  output logic        cmd_seen_o,
  output logic [5:0]  cmd_index_o
);
  state_e state_q, state_d;
  logic desel, rx_stb, rx_bit, tx_ack, tx_en;
  logic [7:0] tx_byte, r1_q, data_q, acmd_cnt_q;
  logic [45:0] sr_q, frame;
  logic [31:0] tail_q, arg, blk_addr_q;
  logic [8:0] cnt_q;
  logic [5:0] cmd_idx, cmd_index_q;
  logic [2:0] rlast_q;
  logic prev_q, rd_q, app_q, in_idle_q, fetch_q, data_req_q, cmd_seen_q, last_bit, accept, busy;
  sd_spi_slave_shifter u_shift (
    .clk(clk), .rst(rst), .spi_clk_i(spi_clk_i), .cs_i(cs_i), .mosi_i(mosi_i),
    .tx_en_i(tx_en), .tx_byte_i(tx_byte), .desel_o(desel), .rx_stb_o(rx_stb),
    .rx_bit_o(rx_bit), .tx_ack_o(tx_ack), .miso_o(miso_o)
  );
  assign frame = {sr_q[44:0], rx_bit};
  assign cmd_idx = frame[45:40];
  assign arg = frame[39:8];
  assign last_bit = state_q == RX_CMD && rx_stb && cnt_q == 9'd45;
  assign accept = last_bit && rx_bit;
  assign busy = acmd_cnt_q < 8'(ACMD41_BUSY_CNT);
  assign tx_en = state_q != HUNT && state_q != RX_CMD;
  assign tx_byte = state_q == TX_RESP ? (cnt_q == 9'd0 ? r1_q : tail_q[31:24]) :
                   state_q == NAC && cnt_q == 9'(NAC_BYTES) ? START_TOKEN :
                   state_q == TX_DATA ? data_q :
                   state_q == TX_CRC ? 8'h00 : 8'hFF;
  assign blk_addr_o = blk_addr_q;
  assign data_req_o = data_req_q;
  assign in_idle_o = in_idle_q;
  assign cmd_seen_o = cmd_seen_q;
  assign cmd_index_o = cmd_index_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (rx_stb && !prev_q && rx_bit) state_d = RX_CMD;
      RX_CMD:  if (last_bit) state_d = rx_bit ? NCR : HUNT;
      NCR:     if (tx_ack && cnt_q == 9'(NCR_BYTES - 1)) state_d = TX_RESP;
      TX_RESP: if (tx_ack && cnt_q == {6'd0, rlast_q}) state_d = rd_q ? NAC : TX_END;
      NAC:     if (tx_ack && cnt_q == 9'(NAC_BYTES)) state_d = TX_DATA;
      TX_DATA: if (tx_ack && cnt_q == 9'(BLOCK_BYTES - 1)) state_d = TX_CRC;
      TX_CRC:  if (tx_ack && cnt_q == 9'd1) state_d = TX_END;
      TX_END:  if (tx_ack) state_d = HUNT;
      default: state_d = HUNT;
    endcase
    if (desel) state_d = HUNT;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= HUNT;
      prev_q <= 1'b1;
      sr_q <= '0;
      cnt_q <= '0;
      in_idle_q <= 1'b1;
      app_q <= 1'b0;
      acmd_cnt_q <= '0;
      cmd_seen_q <= 1'b0;
      cmd_index_q <= '0;
      blk_addr_q <= '0;
      r1_q <= 8'hFF;
      tail_q <= '0;
      rlast_q <= '0;
      rd_q <= 1'b0;
      data_req_q <= 1'b0;
      fetch_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= state_d != state_q ? 9'd0 : cnt_q + 9'((state_q == RX_CMD && rx_stb) || tx_ack);
      cmd_seen_q <= accept;
      // Fetch byte k+1 while byte k is shifting out, leaving a full byte time for the memory
      data_req_q <= tx_ack && ((state_q == NAC && cnt_q == 9'(NAC_BYTES)) ||
                               (state_q == TX_DATA && cnt_q != 9'(BLOCK_BYTES - 1)));
      fetch_q <= data_req_q;
      if (fetch_q) data_q <= data_in_i;
      if (rx_stb) begin
        prev_q <= state_q == HUNT ? rx_bit : 1'b1;
        sr_q <= frame;
      end
      if (desel) prev_q <= 1'b1;
      if (state_q == TX_RESP && tx_ack && cnt_q != 9'd0) tail_q <= tail_q << 8;
      if (accept) begin
        cmd_index_q <= cmd_idx;
        app_q <= cmd_idx == CMD55;
        r1_q <= r1_byte(in_idle_q, 1'b0);
        rlast_q <= 3'd0;
        rd_q <= 1'b0;
        if (cmd_idx == CMD0) begin
          r1_q <= r1_byte(1'b1, 1'b0);
          in_idle_q <= 1'b1;
          acmd_cnt_q <= '0;
        end else if (cmd_idx == CMD8) begin
          rlast_q <= 3'd4;
          tail_q <= {24'h000001, arg[7:0]};
        end else if (cmd_idx == CMD58) begin
          rlast_q <= 3'd4;
          tail_q <= OCR_VALUE;
        end else if (app_q && cmd_idx == ACMD41) begin
          r1_q <= r1_byte(busy, 1'b0);
          if (busy) acmd_cnt_q <= acmd_cnt_q + 8'd1;
          else in_idle_q <= 1'b0;
        end else if (cmd_idx == CMD17) begin
          rd_q <= !in_idle_q;
          if (!in_idle_q) blk_addr_q <= arg;
        end else if (cmd_idx != CMD55) r1_q <= r1_byte(in_idle_q, 1'b1);
      end
    end
endmodule

// File: tb/tb_sd_spi_card_responder.sv
// tb_sd_spi_card_responder: directed host sequences against the SD SPI card responder
module tb_sd_spi_card_responder;
  logic clk = 1'b0, rst = 1'b1, spi_clk = 1'b0, cs = 1'b1, mosi = 1'b1;
  logic miso, data_req, in_idle, cmd_seen;
  logic [31:0] blk_addr;
  logic [7:0] data_in = 8'h00;
  logic [5:0] cmd_index;
  logic [7:0] rsp [0:7];
  int total = 0, bad = 0, req_cnt = 0, req_base = 0, seen_cnt = 0;

  sd_spi_card_responder dut (
    .clk(clk), .rst(rst), .spi_clk_i(spi_clk), .cs_i(cs), .mosi_i(mosi), .miso_o(miso),
    .blk_addr_o(blk_addr), .data_req_o(data_req), .data_in_i(data_in), .in_idle_o(in_idle),
    .cmd_seen_o(cmd_seen), .cmd_index_o(cmd_index)
  );

  always #5 clk = ~clk;

  // one-cycle-latency memory whose byte i within the block is i[7:0]
  always @(posedge clk) begin
    if (data_req) begin
      data_in <= 8'(req_cnt - req_base);
      req_cnt <= req_cnt + 1;
    end
    if (cmd_seen) seen_cnt <= seen_cnt + 1;
  end

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #40 spi_clk = 1'b1;
      rx[i] = miso;
      #40 spi_clk = 1'b0;
    end
    mosi = 1'b1;
  endtask

  task automatic send_cmd(input logic [47:0] f, input int n);
    logic [7:0] r;
    for (int i = 5; i >= 0; i--) xfer(f[i*8 +: 8], r);
    for (int i = 0; i < n; i++) begin
      xfer(8'hFF, r);
      rsp[i] = r;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({miso, in_idle, data_req, cmd_seen} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_flags got=%b want=1100", {miso, in_idle, data_req, cmd_seen});
    end
    total++;
    if ({cmd_index, blk_addr} !== 38'd0) begin
      bad++;
      $display("FAIL reset_regs got idx=%0d addr=%h want 0/0", cmd_index, blk_addr);
    end
  endtask

  task automatic test_cmd0;
    int s = seen_cnt;
    send_cmd(48'h40_00_00_00_00_95, 2);
    total++;
    if ({rsp[0], rsp[1]} !== 16'hFF01) begin
      bad++;
      $display("FAIL cmd0_resp got=%h%h want=ff01", rsp[0], rsp[1]);
    end
    total++;
    if (seen_cnt !== s + 1 || cmd_index !== 6'd0 || in_idle !== 1'b1) begin
      bad++;
      $display("FAIL cmd0_state got seen=%0d idx=%0d idle=%b want %0d/0/1", seen_cnt - s, cmd_index, in_idle, 1);
    end
  endtask

  task automatic test_cmd8;
    logic [47:0] exp = 48'hFF_01_00_00_01_AA;
    send_cmd(48'h48_00_00_01_AA_87, 6);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rsp[i] !== exp[47-8*i -: 8]) begin
        bad++;
        $display("FAIL cmd8_byte%0d got=%h want=%h", i, rsp[i], exp[47-8*i -: 8]);
      end
    end
    total++;
    if (cmd_index !== 6'd8) begin
      bad++;
      $display("FAIL cmd8_index got=%0d want=8", cmd_index);
    end
  endtask

  task automatic test_illegal(input logic [7:0] want);
    send_cmd(48'h49_00_00_00_00_01, 2);
    total++;
    if ({rsp[0], rsp[1]} !== {8'hFF, want}) begin
      bad++;
      $display("FAIL illegal_resp got=%h%h want=ff%h", rsp[0], rsp[1], want);
    end
  endtask

  task automatic test_bad_end_bit;
    int s = seen_cnt;
    send_cmd(48'h7A_00_00_00_00_00, 3);
    total++;
    if ({rsp[0], rsp[1], rsp[2]} !== 24'hFFFFFF || seen_cnt !== s) begin
      bad++;
      $display("FAIL bad_end got=%h%h%h seen=%0d want=ffffff seen=0", rsp[0], rsp[1], rsp[2], seen_cnt - s);
    end
  endtask

  task automatic test_back_to_back_acmd41;
    logic [23:0] exp = 24'h01_01_00;
    for (int k = 0; k < 3; k++) begin
      send_cmd(48'h77_00_00_00_00_01, 2);
      total++;
      if ({rsp[0], rsp[1]} !== 16'hFF01) begin
        bad++;
        $display("FAIL cmd55_%0d got=%h%h want=ff01", k, rsp[0], rsp[1]);
      end
      send_cmd(48'h69_40_00_00_00_01, 2);
      total++;
      if ({rsp[0], rsp[1]} !== {8'hFF, exp[23-8*k -: 8]}) begin
        bad++;
        $display("FAIL acmd41_%0d got=%h%h want=ff%h", k, rsp[0], rsp[1], exp[23-8*k -: 8]);
      end
      total++;
      if (in_idle !== (k < 2)) begin
        bad++;
        $display("FAIL idle_after_acmd41_%0d got=%b want=%b", k, in_idle, k < 2);
      end
    end
  endtask

  task automatic test_cmd58;
    logic [39:0] exp = 40'h00_C0_FF_80_00;
    send_cmd(48'h7A_00_00_00_00_01, 6);
    total++;
    if ({rsp[0], rsp[1], rsp[2], rsp[3], rsp[4], rsp[5]} !== {8'hFF, exp}) begin
      bad++;
      $display("FAIL cmd58_resp got=%h%h%h%h%h%h want=ff%h", rsp[0], rsp[1], rsp[2], rsp[3], rsp[4], rsp[5], exp);
    end
  endtask

  task automatic test_cmd17;
    logic [7:0] r;
    int r0 = req_cnt;
    req_base = req_cnt;
    send_cmd(48'h51_00_00_00_05_01, 5);
    total++;
    if ({rsp[0], rsp[1], rsp[2], rsp[3], rsp[4]} !== 40'hFF00FFFFFE) begin
      bad++;
      $display("FAIL cmd17_head got=%h%h%h%h%h want=ff00fffffe", rsp[0], rsp[1], rsp[2], rsp[3], rsp[4]);
    end
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, r);
      total++;
      if (r !== 8'(i)) begin
        bad++;
        $display("FAIL cmd17_data%0d got=%h want=%h", i, r, 8'(i));
      end
    end
    for (int i = 0; i < 3; i++) begin
      xfer(8'hFF, r);
      total++;
      if (r !== (i == 2 ? 8'hFF : 8'h00)) begin
        bad++;
        $display("FAIL cmd17_tail%0d got=%h want=%h", i, r, i == 2 ? 8'hFF : 8'h00);
      end
    end
    total++;
    if (blk_addr !== 32'd5 || req_cnt - r0 !== 512) begin
      bad++;
      $display("FAIL cmd17_addr_reqs got addr=%0d reqs=%0d want 5/512", blk_addr, req_cnt - r0);
    end
  endtask

  task automatic test_cs_abort;
    logic [7:0] r;
    int r0;
    req_base = req_cnt;
    send_cmd(48'h51_00_00_00_07_01, 5);
    total++;
    if (rsp[1] !== 8'h00 || rsp[4] !== 8'hFE) begin
      bad++;
      $display("FAIL abort_head got r1=%h tok=%h want 00/fe", rsp[1], rsp[4]);
    end
    for (int i = 0; i < 100; i++) begin
      xfer(8'hFF, r);
      total++;
      if (r !== 8'(i)) begin
        bad++;
        $display("FAIL abort_data%0d got=%h want=%h", i, r, 8'(i));
      end
    end
    #160 cs = 1'b1;
    r0 = req_cnt;
    #3000;
    total++;
    if (req_cnt !== r0 || miso !== 1'b1) begin
      bad++;
      $display("FAIL abort_quiet got reqs=%0d miso=%b want 0/1", req_cnt - r0, miso);
    end
    total++;
    if (blk_addr !== 32'd7) begin
      bad++;
      $display("FAIL abort_addr got=%0d want=7", blk_addr);
    end
    cs = 1'b0;
    #100;
    send_cmd(48'h7A_00_00_00_00_01, 2);
    total++;
    if ({rsp[0], rsp[1]} !== 16'hFF00 || cmd_index !== 6'd58) begin
      bad++;
      $display("FAIL abort_cmd58 got=%h%h idx=%0d want=ff00 idx=58", rsp[0], rsp[1], cmd_index);
    end
  endtask

  task automatic test_reset_mid_transfer;
    logic [7:0] r;
    int r0;
    req_base = req_cnt;
    send_cmd(48'h51_00_00_00_09_01, 5);
    for (int i = 0; i < 10; i++) xfer(8'hFF, r);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    r0 = req_cnt;
    total++;
    if ({miso, in_idle, data_req} !== 3'b110 || blk_addr !== 32'd0 || cmd_index !== 6'd0) begin
      bad++;
      $display("FAIL midrst_state got miso=%b idle=%b req=%b addr=%0d idx=%0d want 1/1/0/0/0",
               miso, in_idle, data_req, blk_addr, cmd_index);
    end
    #2000;
    total++;
    if (req_cnt !== r0) begin
      bad++;
      $display("FAIL midrst_reqs got=%0d want=0", req_cnt - r0);
    end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    cs = 1'b0;
    #100;
    test_cmd0;
    test_cmd8;
    test_illegal(8'h05);
    test_bad_end_bit;
    test_back_to_back_acmd41;
    test_cmd58;
    test_cmd17;
    test_illegal(8'h04);
    test_cs_abort;
    test_reset_mid_transfer;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
